// File: rtl/itcm_arb.sv
// itcm_arb: arbiter between instruction fetch (IFU) and load/store (LSU)
// traffic for a single-port ITCM SRAM.
//
// Handshake: a requester holds *_req with a stable payload. *_gnt is
// combinational and means the payload is taken in that same cycle. The
// requester may then change the payload or drop *_req on the closing edge.
// There is no back-pressure on responses. A granted access always answers
// exactly one cycle later, with ifu_ready or lsu_res pulsing for one cycle.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   ifu_req/ifu_pc/ifu_gnt    fetch request, byte address, grant
//   ifu_ready/ifu_inst        fetch response pulse, instruction (held)
//   lsu_req/lsu_store/...     access request, store flag, address, data, byte enables
//   lsu_gnt/lsu_res/lsu_rdata access grant, completion pulse, load data (held)
//   ram_*                     SRAM port; ram_rdata is valid one cycle after a read select
module itcm_arb #(
  parameter int ADDR_W     = 14,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req,
  input  logic [31:0]       ifu_pc,
  output logic              ifu_gnt,
  output logic              ifu_ready,
  output logic [31:0]       ifu_inst,
  input  logic              lsu_req,
  input  logic              lsu_store,
  input  logic [31:0]       lsu_addr,
  input  logic [31:0]       lsu_wdata,
  input  logic [3:0]        lsu_be,
  output logic              lsu_gnt,
  output logic              lsu_res,
  output logic [31:0]       lsu_rdata,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } own_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  own_e        resp_own_q, resp_own_d;
  logic        resp_store_q, resp_store_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] ifu_inst_q, ifu_inst_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic        starve_hit;

  // The byte offset and the address bits above the ITCM size are ignored,
  // so an address beyond the array wraps around onto it.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ifu_pc[31:ADDR_W+2], ifu_pc[1:0],
                              lsu_addr[31:ADDR_W+2], lsu_addr[1:0]};

  assign starve_hit = (starve_cnt_q == STARVE_LIM);

  // Grant and SRAM request. The LSU normally wins. Once the IFU has lost
  // STARVE_MAX cycles in a row, the IFU gets the next slot.
  always_comb begin
    lsu_gnt   = 1'b0;
    ifu_gnt   = 1'b0;
    ram_cs    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = 4'h0;
    ram_addr  = ifu_pc[ADDR_W+1:2];
    ram_wdata = lsu_wdata;
    if (!rst) begin
      lsu_gnt = lsu_req && !(ifu_req && starve_hit);
      ifu_gnt = ifu_req && !lsu_gnt;
    end
    if (lsu_gnt) begin
      ram_cs   = 1'b1;
      ram_we   = lsu_store;
      ram_be   = lsu_be;
      ram_addr = lsu_addr[ADDR_W+1:2];
    end else if (ifu_gnt) begin
      ram_cs   = 1'b1;
    end
  end

  // Response side. The owner register records who launched last cycle's
  // access. The pulses are gated by rst, so an access that was in flight
  // when reset asserts never reports.
  always_comb begin
    ifu_ready = !rst && (resp_own_q == OWN_IFU);
    lsu_res   = !rst && (resp_own_q == OWN_LSU);
    ifu_inst  = 32'h0;
    lsu_rdata = 32'h0;
    if (!rst) begin
      // The data bypasses the hold register in the pulse cycle, so it is
      // valid together with ready/res and not one cycle late.
      ifu_inst  = ifu_ready ? ram_rdata : ifu_inst_q;
      lsu_rdata = (lsu_res && !resp_store_q) ? ram_rdata : lsu_rdata_q;
    end
  end

  // Next-state logic
  always_comb begin
    resp_own_d   = OWN_NONE;
    resp_store_d = 1'b0;
    starve_cnt_d = starve_cnt_q;
    ifu_inst_d   = ifu_inst_q;
    lsu_rdata_d  = lsu_rdata_q;

    if (lsu_gnt) begin
      resp_own_d   = OWN_LSU;
      resp_store_d = lsu_store;
    end else if (ifu_gnt) begin
      resp_own_d   = OWN_IFU;
    end

    // The count only grows while the IFU is actually waiting behind the LSU.
    // Saturating at STARVE_LIM keeps the forced IFU win pending.
    if (!ifu_req || ifu_gnt) begin
      starve_cnt_d = 4'h0;
    end else if (lsu_gnt && (starve_cnt_q < STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + 4'h1;
    end

    if (ifu_ready) begin
      ifu_inst_d = ram_rdata;
    end
    if (lsu_res && !resp_store_q) begin
      lsu_rdata_d = ram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_own_q   <= OWN_NONE;
      resp_store_q <= 1'b0;
      starve_cnt_q <= 4'h0;
      ifu_inst_q   <= 32'h0;
      lsu_rdata_q  <= 32'h0;
    end else begin
      resp_own_q   <= resp_own_d;
      resp_store_q <= resp_store_d;
      starve_cnt_q <= starve_cnt_d;
      ifu_inst_q   <= ifu_inst_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

endmodule

// File: tb/tb_itcm_arb.sv
// Testbench for itcm_arb. It contains a behavioural SRAM, a reference copy
// of the memory contents, and a response scoreboard. Each grant pushes the
// response it must produce one cycle later.
module tb_itcm_arb;

  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              ifu_req;
  logic [31:0]       ifu_pc;
  logic              ifu_gnt;
  logic              ifu_ready;
  logic [31:0]       ifu_inst;
  logic              lsu_req;
  logic              lsu_store;
  logic [31:0]       lsu_addr;
  logic [31:0]       lsu_wdata;
  logic [3:0]        lsu_be;
  logic              lsu_gnt;
  logic              lsu_res;
  logic [31:0]       lsu_rdata;
  logic              ram_cs;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  itcm_arb #(.ADDR_W(ADDR_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_pc(ifu_pc), .ifu_gnt(ifu_gnt),
    .ifu_ready(ifu_ready), .ifu_inst(ifu_inst),
    .lsu_req(lsu_req), .lsu_store(lsu_store), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_be(lsu_be), .lsu_gnt(lsu_gnt),
    .lsu_res(lsu_res), .lsu_rdata(lsu_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // ---------------- behavioural SRAM ----------------
  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];

  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  // ---------------- scoreboard ----------------
  // Entry: {kind[1:0], data}. kind 1 = fetch, 2 = load, 3 = store.
  logic [33:0] exp_q[$];
  logic [31:0] exp_inst;
  logic [31:0] exp_rdata;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_resp();
    logic [33:0] e;
    e = 34'h0;
    if (exp_q.size() != 0) e = exp_q.pop_front();
    if (e[33:32] == 2'd1) exp_inst  = e[31:0];
    if (e[33:32] == 2'd2) exp_rdata = e[31:0];
    chk("ifu_ready", 32'(ifu_ready), 32'(e[33:32] == 2'd1));
    chk("lsu_res",   32'(lsu_res),   32'(e[33:32] >= 2'd2));
    chk("ifu_inst",  ifu_inst,  exp_inst);
    chk("lsu_rdata", lsu_rdata, exp_rdata);
  endtask

  // One clock cycle: drive the requests, then at the falling edge check the
  // response due from last cycle, check the grant and SRAM outputs, and push
  // the response this cycle's grant owes.
  task automatic cyc(input logic ireq, input logic [31:0] pc,
                     input logic lreq, input logic st, input logic [31:0] la,
                     input logic [31:0] wd, input logic [3:0] be,
                     input logic e_ig, input logic e_lg);
    ifu_req = ireq; ifu_pc = pc;
    lsu_req = lreq; lsu_store = st; lsu_addr = la; lsu_wdata = wd; lsu_be = be;
    @(negedge clk);
    check_resp();
    chk("ifu_gnt", 32'(ifu_gnt), 32'(e_ig));
    chk("lsu_gnt", 32'(lsu_gnt), 32'(e_lg));
    chk("ram_cs",  32'(ram_cs),  32'(e_ig | e_lg));
    if (e_lg) begin
      chk("ram_addr_lsu", 32'(ram_addr), 32'(la[15:2]));
      chk("ram_we_lsu", 32'(ram_we), 32'(st));
      chk("ram_be_lsu", 32'(ram_be), 32'(be));
      if (st) begin
        chk("ram_wdata", ram_wdata, wd);
        exp_q.push_back({2'd3, 32'h0});
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[la[15:2]][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_q.push_back({2'd2, ref_mem[la[15:2]]});
      end
    end else if (e_ig) begin
      chk("ram_addr_ifu", 32'(ram_addr), 32'(pc[15:2]));
      chk("ram_we_ifu", 32'(ram_we), 32'h0);
      chk("ram_be_ifu", 32'(ram_be), 32'h0);
      exp_q.push_back({2'd1, ref_mem[pc[15:2]]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ifu_gnt"},   32'(ifu_gnt),   32'h0);
    chk({tag, "_lsu_gnt"},   32'(lsu_gnt),   32'h0);
    chk({tag, "_ram_cs"},    32'(ram_cs),    32'h0);
    chk({tag, "_ram_we"},    32'(ram_we),    32'h0);
    chk({tag, "_ram_be"},    32'(ram_be),    32'h0);
    chk({tag, "_ifu_ready"}, 32'(ifu_ready), 32'h0);
    chk({tag, "_lsu_res"},   32'(lsu_res),   32'h0);
    chk({tag, "_ifu_inst"},  ifu_inst,  32'h0);
    chk({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = 32'(i) * 32'h9E3779B1;
      ref_mem[i] = 32'(i) * 32'h9E3779B1;
    end
    mem[14'h040] = 32'h00500093; ref_mem[14'h040] = 32'h00500093;
    mem[14'h801] = 32'h12345678; ref_mem[14'h801] = 32'h12345678;
    exp_inst  = 32'h0;
    exp_rdata = 32'h0;

    // Reset with both requests high: all grants must stay low.
    rst = 1'b1; ifu_req = 1'b1; ifu_pc = 32'h100; lsu_req = 1'b1;
    lsu_store = 1'b1; lsu_addr = 32'h0; lsu_wdata = 32'h0; lsu_be = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Fetch only: word 0x40 holds 0x00500093.
    cyc(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    idle();
    chk("fetch_inst_hold", ifu_inst, 32'h00500093);

    // Store two low bytes, then load back the merged word.
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'h3, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h2004, 32'h0, 4'h0, 1'b0, 1'b1);
    idle();
    chk("load_merged", lsu_rdata, 32'h1234BEEF);

    // Address wrap: 0x0001_0008 reaches word 2.
    lsu_addr = 32'h0001_0008; lsu_req = 1'b1; lsu_store = 1'b0;
    #1;
    chk("wrap_addr", 32'(ram_addr), 32'h2);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0001_0008, 32'h0, 4'h0, 1'b0, 1'b1);
    idle();

    // Starvation: both held high gives the pattern L,L,L,L,I twice.
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 32'h100 + 32'(4 * k), 1'b1, 1'b0, 32'h0400 + 32'(4 * k),
          32'h0, 4'h0, (k % 5) == 4, (k % 5) != 4);
    end
    idle();

    // Back to back, alternating I,L,I,L, with random addresses.
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0)
        cyc(1'b1, 32'($urandom_range(0, 32'hFFFF)), 1'b0, 1'b0, 32'h0, 32'h0,
            4'h0, 1'b1, 1'b0);
      else
        cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'($urandom_range(0, 32'hFFFF)), 32'h0,
            4'h0, 1'b0, 1'b1);
    end
    idle();

    // A fetch ending a store grant still answers (no blocking).
    cyc(1'b1, 32'h100, 1'b1, 1'b1, 32'h3000, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1);
    cyc(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);

    // Reset in the cycle after a fetch grant: the fetch must not report.
    cyc(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    rst = 1'b1; ifu_req = 1'b1; lsu_req = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("rst_mid_ifu_ready", 32'(ifu_ready), 32'h0);
    chk("rst_mid_ifu_gnt", 32'(ifu_gnt), 32'h0);
    chk("rst_mid_lsu_gnt", 32'(lsu_gnt), 32'h0);
    chk("rst_mid_ram_cs", 32'(ram_cs), 32'h0);
    chk("rst_mid_ram_we", 32'(ram_we), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0;
    exp_inst = 32'h0; exp_rdata = 32'h0;
    @(negedge clk);
    check_all_zero("post_rst");
    @(posedge clk); #1;
    cyc(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/itcm_arb.md
ITCM_ARB -- requirements
Module: itcm_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, meaning ITCM word-address width (2^ADDR_W words).
REQ-002 SHALL have parameter STARVE_MAX, default 4, meaning consecutive IFU-losing cycles before the IFU is forced to win (range 1..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ifu_req  input  1  IFU fetch request.
REQ-006 SHALL have port ifu_pc  input  32  fetch byte address.
REQ-007 SHALL have port ifu_gnt  output  1  fetch accepted this cycle.
REQ-008 SHALL have port ifu_ready  output  1  one-cycle pulse: ifu_inst valid.
REQ-009 SHALL have port ifu_inst  output  32  fetched instruction, held until next ifu_ready.
REQ-010 SHALL have port lsu_req  input  1  LSU access request.
REQ-011 SHALL have port lsu_store  input  1  1 = store, 0 = load.
REQ-012 SHALL have port lsu_addr  input  32  access byte address.
REQ-013 SHALL have port lsu_wdata  input  32  store data.
REQ-014 SHALL have port lsu_be  input  4  store byte enables.
REQ-015 SHALL have port lsu_gnt  output  1  access accepted this cycle.
REQ-016 SHALL have port lsu_res  output  1  one-cycle pulse: access complete, lsu_rdata valid.
REQ-017 SHALL have port lsu_rdata  output  32  load data, held until next lsu_res.
REQ-018 SHALL have port ram_cs  output  1  SRAM select.
REQ-019 SHALL have port ram_we  output  1  SRAM write.
REQ-020 SHALL have port ram_be  output  4  SRAM byte write enables.
REQ-021 SHALL have port ram_addr  output  ADDR_W  SRAM word address.
REQ-022 SHALL have port ram_wdata  output  32  SRAM write data.
REQ-023 SHALL have port ram_rdata  input  32  SRAM read data, valid the cycle after ram_cs with ram_we=0.

Function
REQ-024 SHALL grant at most one requester per cycle; gnt is combinational from req, counter and rst.
REQ-025 SHALL sample payload in the grant cycle; requester may change payload or drop req on the clock edge ending that cycle.
REQ-026 SHALL drive ram_cs=1 in each grant cycle, with ram_addr = granted address bits [ADDR_W+1:2]; bits [1:0] and bits above ADDR_W+1 ignored (address wraps).
REQ-027 SHALL drive ram_we=lsu_store and ram_be=lsu_be for an LSU grant, ram_we=0 and ram_be=0 for an IFU grant, ram_wdata=lsu_wdata always.
REQ-028 SHALL be LSU-priority: both requesting -> LSU granted unless starve_cnt == STARVE_MAX, then IFU granted.
REQ-029 SHALL increment 4-bit starve_cnt when ifu_req=1 and lsu_gnt=1, clear it when ifu_gnt=1 or ifu_req=0, and never exceed STARVE_MAX.
REQ-030 SHALL track the in-flight owner in register resp_own (NONE/IFU/LSU), loaded every cycle from the grant (NONE if no grant).
REQ-031 SHALL, with resp_own=IFU, pulse ifu_ready and register ifu_inst <= ram_rdata; latency grant->ready exactly 1 cycle.
REQ-032 SHALL, with resp_own=LSU, pulse lsu_res; on loads register lsu_rdata <= ram_rdata, on stores leave lsu_rdata unchanged.
REQ-033 SHALL support back-to-back grants every cycle (full throughput, including alternating IFU/LSU).
REQ-034 SHALL not block on responses: a new grant may occur in a response cycle.
REQ-035 SHALL leave ifu_inst and lsu_rdata unchanged in cycles without the corresponding response.

Reset
REQ-036 SHALL, while rst=1, force ifu_gnt, lsu_gnt, ram_cs, ram_we = 0 regardless of requests.
REQ-037 SHALL reset ifu_ready, lsu_res, ram_be, ifu_inst, lsu_rdata, starve_cnt to 0 and resp_own to NONE.
REQ-038 SHALL discard an access granted in the cycle before rst asserts: no ready/res pulse follows reset.

Verification
REQ-039 SHALL verify IFU-only: ifu_req=1, ifu_pc=0x100, RAM word 0x40=0x00500093 -> ifu_gnt that cycle, ram_addr=0x40, ifu_ready next cycle with ifu_inst=0x00500093.
REQ-040 SHALL verify store then load: store addr 0x2004, wdata 0xDEADBEEF, be=0x3 -> ram_we=1, ram_be=0x3, lsu_res +1 cycle, lsu_rdata unchanged; load 0x2004 -> lsu_rdata=0x????BEEF per old upper bytes.
REQ-041 SHALL verify starvation: ifu_req and lsu_req held 1 continuously, STARVE_MAX=4 -> grant pattern L,L,L,L,I repeating.
REQ-042 SHALL verify back-to-back: alternating single-cycle grants I,L,I,L -> ready/res pulses in matching order one cycle later, no lost or duplicated response.
REQ-043 SHALL verify reset mid-operation: rst asserted the cycle after an IFU grant -> no ifu_ready, all outputs 0, first grant possible the cycle after rst deasserts.
REQ-044 SHALL verify address wrap: lsu_addr=0x0001_0008 with ADDR_W=14 -> ram_addr=0x0002.
